// File: rtl/cpu7_ifu_ibuf.sv
// cpu7_ifu_ibuf: instruction buffer between the icache response path and decode.
// A DEPTH-entry circular FIFO holding each fetched instruction with its PC,
// branch-prediction and exception sideband. The head entry is shown ahead on
// fdp_dec_*, execute stalls hold it there, and a flush discards everything.
// Optional feature: define CPU7_IFU_IBUF_BYPASS_EN to let an entry arriving
// at an empty, unstalled buffer go straight to decode in the same cycle.
module cpu7_ifu_ibuf #(
   parameter int DEPTH           = 4,
   parameter int GRLEN           = 32,
   parameter int LSOC1K_PRU_HINT = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         icu_ifu_valid,
   input  logic [GRLEN-1:0]             icu_ifu_pc,
   input  logic [31:0]                  icu_ifu_inst,
   input  logic [GRLEN-3:0]             icu_ifu_br_target,
   input  logic                         icu_ifu_br_taken,
   input  logic                         icu_ifu_exception,
   input  logic [5:0]                   icu_ifu_exccode,
   input  logic [LSOC1K_PRU_HINT-1:0]   icu_ifu_hint,
   output logic                         ifu_icu_ready,
   input  logic                         exu_ifu_stall,
   input  logic                         exu_ifu_flush,
   output logic                         fdp_dec_valid,
   output logic [GRLEN-1:0]             fdp_dec_pc,
   output logic [31:0]                  fdp_dec_inst,
   output logic [GRLEN-3:0]             fdp_dec_br_target,
   output logic                         fdp_dec_br_taken,
   output logic                         fdp_dec_exception,
   output logic [5:0]                   fdp_dec_exccode,
   output logic [LSOC1K_PRU_HINT-1:0]   fdp_dec_hint,
   output logic [$clog2(DEPTH):0]       ifu_ibuf_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = GRLEN + 32 + (GRLEN - 2) + 1 + 1 + 6 + LSOC1K_PRU_HINT;

   logic [EW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;

   logic [EW-1:0] w_inEntry;
   logic [EW-1:0] w_headEntry;
   logic [EW-1:0] w_outEntry;
   logic          w_full;
   logic          w_empty;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;

   assign w_inEntry   = {icu_ifu_pc, icu_ifu_inst, icu_ifu_br_target, icu_ifu_br_taken,
                         icu_ifu_exception, icu_ifu_exccode, icu_ifu_hint};
   assign w_headEntry = r_mem[r_rdPtr];

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Ready looks only at the registered count, so a same-cycle pop never
   // makes room for a push; flush also refuses the incoming entry.
   assign ifu_icu_ready = !w_full && !exu_ifu_flush;

`ifdef CPU7_IFU_IBUF_BYPASS_EN
   assign w_bypass = w_empty && icu_ifu_valid && !exu_ifu_stall && !exu_ifu_flush;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed entry is consumed directly by decode and never stored.
   assign w_pop  = !w_empty && !exu_ifu_stall && !exu_ifu_flush;
   assign w_push = icu_ifu_valid && ifu_icu_ready && !w_bypass;

   assign fdp_dec_valid  = w_pop || w_bypass;
   assign w_outEntry     = w_bypass ? w_inEntry : w_headEntry;
   assign {fdp_dec_pc, fdp_dec_inst, fdp_dec_br_target, fdp_dec_br_taken,
           fdp_dec_exception, fdp_dec_exccode, fdp_dec_hint} = w_outEntry;
   assign ifu_ibuf_count = r_count;

   // Storage is written on every accepted push and is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_inEntry;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over any push or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (exu_ifu_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
